// File: rtl/md_ctrl_pkg.sv
// rtl/md_ctrl_pkg.sv - shared md_op/state encodings and default latencies for the mul/div unit
package md_ctrl_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam int MD_MUL_LAT = 5;
    localparam int MD_DIV_LAT = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// rtl/md_ctrl_if.sv - E-stage issue and HI/LO readback bundle for md_ctrl
interface md_ctrl_if;
    import md_ctrl_pkg::*;

    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_ctrl_arith.sv
// rtl/md_ctrl_arith.sv - combinational 32-bit signed/unsigned multiply and divide
module md_arith
    import md_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic        [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;

    assign sa     = a;
    assign sb     = b;
    // Sign-extending to 64 bits first makes the truncated product the signed result
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'b0, a} * {32'b0, b};

    always_comb begin
        quot_s = '0;
        rem_s  = '0;
        if (b != 32'd0) begin
            quot_s = sa / sb;
            rem_s  = sa % sb;
        end
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) begin
                    res_hi = a;
                    res_lo = 32'hFFFF_FFFF;
                end else if (op == MD_DIVU) begin
                    res_hi = a % b;
                    res_lo = a / b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    // The only signed quotient that does not fit; wrap it explicitly
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - HI/LO owner and fixed-latency mult/div sequencer for the E stage
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT,
    parameter int DIV_LAT = MD_DIV_LAT
) (
    input  logic      clk,
    input  logic      reset_n,
    md_ctrl_if.slave  md
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    md_result_t    hilo;
    md_result_t    pend;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    md_arith u_arith (
        .a      (md.src_a),
        .b      (md.src_b),
        .op     (md.md_op),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // The start term lets the hazard unit stall the very next issue slot
    assign md.busy = reset_n && ((state != ST_IDLE) ||
                     (md.start && (is_mul(md.md_op) || is_div(md.md_op))));
    assign md.hi   = hilo.hi;
    assign md.lo   = hilo.lo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hilo  <= '0;
            pend  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md.start) begin
                        if (is_mul(md.md_op)) begin
                            state <= ST_MUL;
                            cnt   <= CW'(MUL_LAT);
                            pend  <= '{hi: res_hi, lo: res_lo};
                        end else if (is_div(md.md_op)) begin
                            state <= ST_DIV;
                            cnt   <= CW'(DIV_LAT);
                            pend  <= '{hi: res_hi, lo: res_lo};
                        end else if (md.md_op == MD_MTHI) begin
                            hilo.hi <= md.src_a;
                        end else if (md.md_op == MD_MTLO) begin
                            hilo.lo <= md.src_a;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt == CW'(1)) begin
                        hilo  <= pend;
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - scoreboard bench for md_ctrl timing, arithmetic, mt*, ignore and reset cases
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    md_ctrl_if mdi ();

    md_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (mdi)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic step_in;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdi.start = st;
        mdi.md_op = op;
        mdi.src_a = a;
        mdi.src_b = b;
    endtask

    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MD_MULT:  return sa * sb;
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Issue op in cycle 0, scramble operands afterwards, count busy cycles, check commit
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] exp,
                          input bit intrude);
        int          nbusy;
        bit          done;
        logic [63:0] e;
        nbusy = 0;
        done  = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            step_in;
            if (cyc == 0) begin
                drive(1'b1, op, a, b);
                exp_q.push_back(exp);
            end else if (intrude && cyc == 3) begin
                drive(1'b1, MD_DIV, 32'd100, 32'd7);
            end else if (intrude && cyc == 4) begin
                drive(1'b1, MD_MTHI, 32'hCAFE_F00D, 32'd0);
            end else begin
                drive(1'b0, MD_NONE, $urandom, $urandom);
            end
            @(negedge clk);
            if (mdi.busy) nbusy++;
            else          done = 1'b1;
        end
        chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(lat + 1));
        e = exp_q.pop_front();
        if (done) chk({tag, "_hilo"}, {mdi.hi, mdi.lo}, e);
        else      chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] ra, rb;

        reset_n = 1'b0;
        drive(1'b1, MD_MULT, 32'd3, 32'd4);
        #12;
        chk("rst_busy", 64'(mdi.busy), 64'd0);
        chk("rst_hilo", {mdi.hi, mdi.lo}, 64'd0);
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_md("mult",   MD_MULT,  32'hFFFF_FFFE, 32'd3, 5,  {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1'b0);
        run_md("multu",  MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5,  {32'h0000_0002, 32'hFFFF_FFFA}, 1'b0);
        run_md("div",    MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_md("divu",   MD_DIVU,  32'd7,         32'd2, 10, {32'd1, 32'd3},                 1'b0);
        run_md("div0",   MD_DIV,   32'h1234_5678, 32'd0, 10, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b0);
        run_md("divovf", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, {32'd0, 32'h8000_0000}, 1'b0);

        for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom;
            run_md($sformatf("rand%0d", i), op, ra, rb, is_mul(op) ? 5 : 10, ref_md(op, ra, rb), 1'b0);
        end

        step_in;
        drive(1'b1, MD_MTHI, 32'hDEAD_BEEF, 32'd0);
        @(negedge clk);
        chk("mthi_busy", 64'(mdi.busy), 64'd0);
        step_in;
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        @(negedge clk);
        chk("mthi_hi", 64'(mdi.hi), 64'hDEAD_BEEF);
        step_in;
        drive(1'b1, MD_MTLO, 32'd1, 32'd0);
        @(negedge clk);
        chk("mtlo_busy", 64'(mdi.busy), 64'd0);
        step_in;
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        @(negedge clk);
        chk("mtlo_hilo", {mdi.hi, mdi.lo}, {32'hDEAD_BEEF, 32'd1});

        step_in;
        drive(1'b1, 3'd7, 32'h5555_5555, 32'd9);
        @(negedge clk);
        chk("op7_busy", 64'(mdi.busy), 64'd0);
        step_in;
        drive(1'b0, MD_NONE, 32'd0, 32'd0);
        @(negedge clk);
        chk("op7_hilo", {mdi.hi, mdi.lo}, {32'hDEAD_BEEF, 32'd1});

        run_md("ignore", MD_MULT, 32'h0001_0000, 32'h0001_0003, 5, {32'd1, 32'h0003_0000}, 1'b1);

        step_in;
        drive(1'b1, MD_DIV, 32'd1000, 32'd3);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            step_in;
            drive(1'b0, MD_NONE, 32'd0, 32'd0);
        end
        reset_n = 1'b0;
        #2;
        chk("midrst_busy", 64'(mdi.busy), 64'd0);
        chk("midrst_hilo", {mdi.hi, mdi.lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int cyc = 5; cyc <= 12; cyc++) begin
            step_in;
            @(negedge clk);
            if (cyc >= 11) begin
                chk($sformatf("nocommit_hilo_c%0d", cyc), {mdi.hi, mdi.lo}, 64'd0);
                chk($sformatf("nocommit_busy_c%0d", cyc), 64'(mdi.busy), 64'd0);
            end
        end
        run_md("post_rst_multu", MD_MULTU, 32'd5, 32'd6, 5, {32'd0, 32'd30}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
